// File: rtl/iopmp_check_arbiter_if.sv
// Request/response channels between the DMA requesters and the arbiter, plus the
// combinational iopmp check port the arbiter drives.
interface iopmp_check_arbiter_if #(
    parameter int PLEN       = 34,
    parameter int NR_MASTERS = 2,
    parameter int ACC_W      = 3
);
    localparam int SID_W = (NR_MASTERS == 1) ? 1 : $clog2(NR_MASTERS);

    // Handshake: a request for master m transfers on a clock edge where
    // req_valid_i[m] && req_ready_o[m]; its verdict transfers where
    // rsp_valid_o[m] && rsp_ready_i[m]. A valid side holds its payload until that edge.
    logic [NR_MASTERS-1:0]       req_valid_i;
    logic [NR_MASTERS-1:0]       req_ready_o;
    logic [NR_MASTERS*PLEN-1:0]  req_addr_i;
    logic [NR_MASTERS*ACC_W-1:0] req_access_i;
    logic [NR_MASTERS-1:0]       rsp_valid_o;
    logic                        rsp_allow_o;
    logic [NR_MASTERS-1:0]       rsp_ready_i;
    logic [PLEN-1:0]             iopmp_addr_o;
    logic [SID_W-1:0]            iopmp_sid_o;
    logic [ACC_W-1:0]            iopmp_access_o;
    logic                        iopmp_allow_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_access_i, rsp_ready_i, iopmp_allow_i,
        output req_ready_o, rsp_valid_o, rsp_allow_o, iopmp_addr_o, iopmp_sid_o, iopmp_access_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_access_i, rsp_ready_i, iopmp_allow_i,
        input  req_ready_o, rsp_valid_o, rsp_allow_o, iopmp_addr_o, iopmp_sid_o, iopmp_access_o
    );
endinterface

// File: rtl/iopmp_check_arbiter.sv
// Round-robin sharing of one iopmp check port among NR_MASTERS requesters; one check in
// flight, registered verdict returned over a per-master valid/ready response channel.
module iopmp_check_arbiter #(
    parameter int PLEN       = 34,
    parameter int NR_MASTERS = 2,
    parameter int ACC_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    iopmp_check_arbiter_if.slave bus,
    output logic [CNT_W-1:0]     deny_cnt_o,
    output logic                 busy_o,
    output logic [1:0]           dbg_state_o
);
    localparam int SID_W = (NR_MASTERS == 1) ? 1 : $clog2(NR_MASTERS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [SID_W-1:0]      r_ptr, r_grant, w_grant, w_ptr_nxt;
    logic [PLEN-1:0]       r_addr;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_verdict;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_found, w_accept;
    logic [NR_MASTERS-1:0] w_req_ready, w_rsp_valid;

    // First valid master at or after the round-robin pointer, wrapping to 0.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NR_MASTERS) idx = idx - NR_MASTERS;
            if (!w_found && bus.req_valid_i[idx]) begin
                w_found = 1'b1;
                w_grant = SID_W'(idx);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_grant) == NR_MASTERS - 1) ? '0 : w_grant + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_req_ready = '0;
        w_rsp_valid = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept             = 1'b1;
                    w_req_ready[w_grant] = 1'b1;
                    w_state_nxt          = S_CHECK;
                end
            end
            S_CHECK: w_state_nxt = S_RESP;
            S_RESP: begin
                w_rsp_valid[r_grant] = 1'b1;
                if (bus.rsp_ready_i[r_grant]) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_addr    <= '0;
            r_acc     <= '0;
            r_verdict <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr   <= w_ptr_nxt;
                r_grant <= w_grant;
                r_addr  <= bus.req_addr_i[int'(w_grant)*PLEN +: PLEN];
                r_acc   <= bus.req_access_i[int'(w_grant)*ACC_W +: ACC_W];
            end
            // The iopmp answer is combinational on the registered addr/sid/access.
            if (r_state == S_CHECK) begin
                r_verdict <= bus.iopmp_allow_i;
                if (!bus.iopmp_allow_i && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.req_ready_o    = w_req_ready;
    assign bus.rsp_valid_o    = w_rsp_valid;
    assign bus.rsp_allow_o    = r_verdict;
    assign bus.iopmp_addr_o   = r_addr;
    assign bus.iopmp_sid_o    = r_grant;
    assign bus.iopmp_access_o = r_acc;
    assign deny_cnt_o         = r_cnt;
    assign busy_o             = (r_state != S_IDLE);
    assign dbg_state_o        = r_state;
endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// Bench for iopmp_check_arbiter: table of single checks, round-robin, saturation,
// response back-pressure and asynchronous reset sequences, with a response scoreboard.
module tb_iopmp_check_arbiter;
    localparam int PLEN  = 34;
    localparam int NR    = 2;
    localparam int ACC_W = 3;
    localparam int CNT_W = 4;
    localparam int SID_W = 1;
    localparam int SB_W  = 18;

    logic       clk = 1'b0;
    logic       rst_n;
    bit         iopmp_en;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [CNT_W-1:0] deny_cnt;
    logic             busy;
    logic [1:0]       dbg_state;

    logic [SB_W-1:0] exp_q[$];

    iopmp_check_arbiter_if #(.PLEN(PLEN), .NR_MASTERS(NR), .ACC_W(ACC_W)) bus ();

    iopmp_check_arbiter #(.PLEN(PLEN), .NR_MASTERS(NR), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .deny_cnt_o (deny_cnt),
        .busy_o     (busy),
        .dbg_state_o(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in iopmp policy: deny top nibble F of addr[31:28], deny sid 1 doing access 2.
    function automatic bit model_allow(logic [PLEN-1:0] a, logic [SID_W-1:0] s, logic [ACC_W-1:0] acc);
        return (a[31:28] != 4'hF) && !((s == 1'b1) && (acc == 3'd2));
    endfunction

    assign bus.iopmp_allow_i = iopmp_en & model_allow(bus.iopmp_addr_o, bus.iopmp_sid_o, bus.iopmp_access_o);

    function automatic logic [NR-1:0] onehot(int m);
        logic [NR-1:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(logic [NR-1:0] v, int p);
        for (int i = 0; i < NR; i++) begin
            int j = (p + i) % NR;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expectation pushed at acceptance, popped at the response handshake.
    int               m_ptr;
    int               pick;
    bit               rsp_open;
    bit               exp_allow;
    logic [CNT_W-1:0] exp_cnt_m;
    logic [PLEN-1:0]  ma;
    logic [ACC_W-1:0] macc;
    logic [SB_W-1:0]  e;
    logic [15:0]      lat;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr     = 0;
            exp_cnt_m = '0;
            rsp_open  = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.req_ready_o != '0) begin
                pick = rr_pick(bus.req_valid_i, m_ptr);
                chk("grant_onehot", 64'(bus.req_ready_o), 64'(onehot(pick)));
                chk("ready_without_valid", 64'(bus.req_ready_o & ~bus.req_valid_i), 0);
                ma        = bus.req_addr_i[pick*PLEN +: PLEN];
                macc      = bus.req_access_i[pick*ACC_W +: ACC_W];
                exp_allow = iopmp_en & model_allow(ma, 1'(pick), macc);
                exp_q.push_back({16'(cyc), 1'(pick), exp_allow});
                m_ptr = (pick + 1) % NR;
            end
            if (bus.rsp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus.rsp_valid_o), 0);
                end else begin
                    e = exp_q[0];
                    chk("rsp_master", 64'(bus.rsp_valid_o), 64'(onehot(int'(e[1]))));
                    chk("rsp_allow", 64'(bus.rsp_allow_o), 64'(e[0]));
                    if (!rsp_open) begin
                        lat = 16'(cyc) - e[17:2];
                        chk("rsp_latency", 64'(lat), 2);
                        if (!e[0] && (exp_cnt_m != '1)) exp_cnt_m = exp_cnt_m + 1'b1;
                        chk("deny_cnt", 64'(deny_cnt), 64'(exp_cnt_m));
                        rsp_open = 1'b1;
                    end
                    if (bus.rsp_ready_i[e[1]]) begin
                        void'(exp_q.pop_front());
                        rsp_open = 1'b0;
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic drive_req(input int m, input logic [PLEN-1:0] a, input logic [ACC_W-1:0] acc);
        bus.req_addr_i[m*PLEN +: PLEN]     = a;
        bus.req_access_i[m*ACC_W +: ACC_W] = acc;
        bus.req_valid_i[m]                 = 1'b1;
    endtask

    task automatic wait_ready(input int m, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready_o[m]) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: req_ready_o[%0d] got 0 within 20 cycles, expected 1", name, m);
        end
    endtask

    task automatic wait_any_ready(output logic [NR-1:0] rv);
        rv = '0;
        for (int i = 0; i < 20 && rv == '0; i++) begin
            @(negedge clk);
            rv = bus.req_ready_o;
        end
    endtask

    // One isolated check; returns right after the response handshake edge.
    task automatic do_txn(input int m, input logic [PLEN-1:0] a, input logic [ACC_W-1:0] acc,
                          input bit en, input bit x_allow, input logic [CNT_W-1:0] x_cnt,
                          input string name);
        iopmp_en = en;
        drive_req(m, a, acc);
        wait_ready(m, {name, "_accept"});
        @(posedge clk); #1;
        bus.req_valid_i[m] = 1'b0;
        @(negedge clk);
        chk({name, "_iopmp_addr"}, 64'(bus.iopmp_addr_o), 64'(a));
        chk({name, "_iopmp_sid"}, 64'(bus.iopmp_sid_o), 64'(m));
        chk({name, "_iopmp_acc"}, 64'(bus.iopmp_access_o), 64'(acc));
        @(negedge clk);
        chk({name, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(onehot(m)));
        chk({name, "_rsp_allow"}, 64'(bus.rsp_allow_o), 64'(x_allow));
        chk({name, "_deny_cnt"}, 64'(deny_cnt), 64'(x_cnt));
        @(posedge clk); #1;
    endtask

    typedef struct {
        int               m;
        logic [PLEN-1:0]  addr;
        logic [ACC_W-1:0] acc;
        bit               en;
        bit               exp_allow;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [NR-1:0] rv;
        int            prev;
        int            x;

        vecs[0] = '{m: 0, addr: 34'h0_0000_1000, acc: 3'd1, en: 1'b1, exp_allow: 1'b1, exp_cnt: 4'd0};
        vecs[1] = '{m: 1, addr: 34'h0_0000_2000, acc: 3'd1, en: 1'b1, exp_allow: 1'b1, exp_cnt: 4'd0};
        vecs[2] = '{m: 1, addr: 34'h0_0000_3000, acc: 3'd2, en: 1'b1, exp_allow: 1'b0, exp_cnt: 4'd1};
        vecs[3] = '{m: 0, addr: 34'h0_0000_3000, acc: 3'd2, en: 1'b1, exp_allow: 1'b1, exp_cnt: 4'd1};
        vecs[4] = '{m: 0, addr: 34'h0_F000_0000, acc: 3'd1, en: 1'b1, exp_allow: 1'b0, exp_cnt: 4'd2};
        vecs[5] = '{m: 1, addr: 34'h2_0000_0004, acc: 3'd4, en: 1'b0, exp_allow: 1'b0, exp_cnt: 4'd3};
        vecs[6] = '{m: 0, addr: 34'h3_FFFF_FFFF, acc: 3'd7, en: 1'b1, exp_allow: 1'b0, exp_cnt: 4'd4};
        vecs[7] = '{m: 1, addr: 34'h1_0000_0000, acc: 3'd7, en: 1'b1, exp_allow: 1'b1, exp_cnt: 4'd4};

        rst_n            = 1'b0;
        iopmp_en         = 1'b1;
        bus.req_valid_i  = '0;
        bus.req_addr_i   = '0;
        bus.req_access_i = '0;
        bus.rsp_ready_i  = '1;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready_o), 0);
        chk("reset_rsp_valid", 64'(bus.rsp_valid_o), 0);
        chk("reset_rsp_allow", 64'(bus.rsp_allow_o), 0);
        chk("reset_iopmp_out", 64'({bus.iopmp_addr_o, bus.iopmp_sid_o, bus.iopmp_access_o}), 0);
        chk("reset_deny_cnt", 64'(deny_cnt), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_state", 64'(dbg_state), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].m, vecs[i].addr, vecs[i].acc, vecs[i].en,
                   vecs[i].exp_allow, vecs[i].exp_cnt, $sformatf("vec%0d", i));
        end

        // Both masters continuously valid; the table ended on master 1, so master 0 is next.
        iopmp_en = 1'b1;
        drive_req(0, 34'h0_0000_4000, 3'd1);
        drive_req(1, 34'h0_0000_5000, 3'd1);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready(rv);
            chk("rr_grant", 64'(rv), (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k > 0) chk("rr_spacing", 64'(cyc - prev), 3);
            prev = cyc;
        end
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        repeat (4) @(negedge clk);
        chk("rr_drain", 64'(exp_q.size()), 0);
        @(posedge clk); #1;

        // Deny counter saturates at all-ones (4 denies so far).
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            x = (4 + i + 1 > 15) ? 15 : 4 + i + 1;
            do_txn(1, 34'h0_0000_9000, 3'd1, 1'b0, 1'b0, 4'(x), "sat");
        end
        chk("sat_final", 64'(deny_cnt), 'hF);

        // Response held off with rsp_ready all 0 while master 0 waits.
        iopmp_en        = 1'b1;
        bus.rsp_ready_i = '0;
        drive_req(1, 34'h0_0000_6000, 3'd1);
        wait_ready(1, "stall_accept");
        @(posedge clk); #1;
        bus.req_valid_i[1] = 1'b0;
        drive_req(0, 34'h0_0000_7000, 3'd1);
        @(negedge clk);
        chk("stall_check_ready", 64'(bus.req_ready_o), 0);
        chk("stall_check_state", 64'(dbg_state), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(bus.rsp_valid_o), 'h2);
            chk("stall_rsp_allow", 64'(bus.rsp_allow_o), 1);
            chk("stall_req_ready", 64'(bus.req_ready_o), 0);
            chk("stall_busy", 64'(busy), 1);
        end
        @(posedge clk); #1;
        bus.rsp_ready_i = 2'b10;
        @(negedge clk);
        chk("stall_rsp_hs", 64'(bus.rsp_valid_o), 'h2);
        @(posedge clk); #1;
        bus.rsp_ready_i = '1;
        @(negedge clk);
        chk("stall_m0_next", 64'(bus.req_ready_o), 'h1);
        @(posedge clk); #1;
        bus.req_valid_i[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        // Master 0's ready must not complete master 1's response.
        bus.rsp_ready_i = 2'b01;
        drive_req(1, 34'h0_0000_8000, 3'd1);
        wait_ready(1, "other_accept");
        @(posedge clk); #1;
        bus.req_valid_i[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("other_rsp_held", 64'(bus.rsp_valid_o), 'h2);
        end
        @(posedge clk); #1;
        bus.rsp_ready_i = 2'b10;
        @(negedge clk);
        chk("other_rsp_hs", 64'(bus.rsp_valid_o), 'h2);
        @(posedge clk); #1;
        bus.rsp_ready_i = '1;
        @(negedge clk);
        chk("other_idle", 64'(busy), 0);
        @(posedge clk); #1;

        // Asynchronous reset while a verdict is waiting in RESP.
        bus.rsp_ready_i = '0;
        drive_req(0, 34'h0_0000_A000, 3'd1);
        wait_ready(0, "arst_accept");
        @(posedge clk); #1;
        bus.req_valid_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_pre_valid", 64'(bus.rsp_valid_o), 'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(bus.rsp_valid_o), 0);
        chk("arst_rsp_allow", 64'(bus.rsp_allow_o), 0);
        chk("arst_deny_cnt", 64'(deny_cnt), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_iopmp_addr", 64'(bus.iopmp_addr_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n           = 1'b1;
        bus.rsp_ready_i = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_rsp", 64'(bus.rsp_valid_o), 0);
            chk("arst_no_busy", 64'(busy), 0);
        end
        @(posedge clk); #1;
        drive_req(0, 34'h0_0000_B000, 3'd1);
        drive_req(1, 34'h0_0000_C000, 3'd1);
        wait_any_ready(rv);
        chk("arst_ptr_reset", 64'(rv), 'h1);
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        repeat (4) @(negedge clk);
        chk("final_drain", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
